// File: rtl/point_test_checker.sv
// point_test_checker: per-lane error accumulator and pass/fail evaluator for
// an MBTRAIN point test, sitting just upstream of the link-speed stage.
// Latency: ack and lane results appear test_length + 3 cycles after en rises
//          when a valid beat arrives every cycle.
// Backpressure: none; the test window simply stretches over invalid beats.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   i_point_test_en                 level request, held for the whole test
//   i_tx_lfsr_or_perlane            pattern select, latched and forwarded
//   i_tx_mainband_or_valtrain_test  1 = data-lane test, 0 = valid-lane test
//   i_test_length                   valid beats in the test window
//   i_error_threshold               max tolerated errors per lane (inclusive)
//   i_beat_valid                    mismatch inputs meaningful this cycle
//   i_lane_mismatch                 per-lane compare error for this beat
//   i_valid_mismatch                valid-lane compare error for this beat
//   o_pattern_gen_en                pattern generator enable (test window)
//   o_pattern_lfsr                  latched pattern select
//   o_point_test_ack                results valid, held while en stays high
//   o_lanes_result                  1 = lane passed
//   o_busy                          high whenever not idle

module point_test_checker #(
  parameter int LANES = 16,
  parameter int CNT_W = 12,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_point_test_en,
  input  logic             i_tx_lfsr_or_perlane,
  input  logic             i_tx_mainband_or_valtrain_test,
  input  logic [LEN_W-1:0] i_test_length,
  input  logic [CNT_W-1:0] i_error_threshold,
  input  logic             i_beat_valid,
  input  logic [LANES-1:0] i_lane_mismatch,
  input  logic             i_valid_mismatch,
  output logic             o_pattern_gen_en,
  output logic             o_pattern_lfsr,
  output logic             o_point_test_ack,
  output logic [LANES-1:0] o_lanes_result,
  output logic             o_busy
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    EVAL,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [CNT_W-1:0] lane_cnt [LANES];
  logic [CNT_W-1:0] vld_cnt;
  logic [LEN_W-1:0] beat_cnt;
  logic [LEN_W-1:0] beat_nxt;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] thr_q;
  logic             mainband_q;
  logic [LANES-1:0] pass_vec;

  // beat_cnt never exceeds len_q - 1 while in RUN, so this cannot overflow.
  assign beat_nxt = beat_cnt + 1'b1;

  // Pass/fail evaluation from the saturated counters. In valtrain mode the
  // single valid-lane verdict is broadcast to every result bit.
  always_comb begin
    pass_vec = '0;
    for (int i = 0; i < LANES; i++) begin
      if (mainband_q) begin
        pass_vec[i] = (lane_cnt[i] <= thr_q);
      end else begin
        pass_vec[i] = (vld_cnt <= thr_q);
      end
    end
    // A zero-length window has seen no data, so nothing can have failed.
    if (len_q == '0) begin
      pass_vec = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      o_pattern_gen_en <= 1'b0;
      o_pattern_lfsr   <= 1'b0;
      o_point_test_ack <= 1'b0;
      o_lanes_result   <= '0;
      o_busy           <= 1'b0;
      beat_cnt         <= '0;
      len_q            <= '0;
      thr_q            <= '0;
      mainband_q       <= 1'b0;
      vld_cnt          <= '0;
      for (int i = 0; i < LANES; i++) begin
        lane_cnt[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (i_point_test_en) begin
            state          <= CLEAR;
            o_busy         <= 1'b1;
            o_lanes_result <= '0;
            beat_cnt       <= '0;
            vld_cnt        <= '0;
            for (int i = 0; i < LANES; i++) begin
              lane_cnt[i] <= '0;
            end
          end
        end

        CLEAR: begin
          if (!i_point_test_en) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else begin
            // Configuration is frozen here for the rest of the test.
            len_q          <= i_test_length;
            thr_q          <= i_error_threshold;
            mainband_q     <= i_tx_mainband_or_valtrain_test;
            o_pattern_lfsr <= i_tx_lfsr_or_perlane;
            if (i_test_length == '0) begin
              state <= EVAL;
            end else begin
              state            <= RUN;
              o_pattern_gen_en <= 1'b1;
            end
          end
        end

        RUN: begin
          if (!i_point_test_en) begin
            state            <= IDLE;
            o_busy           <= 1'b0;
            o_pattern_gen_en <= 1'b0;
          end else if (i_beat_valid) begin
            beat_cnt <= beat_nxt;
            if (mainband_q) begin
              for (int i = 0; i < LANES; i++) begin
                if (i_lane_mismatch[i] && (lane_cnt[i] != CNT_MAX)) begin
                  lane_cnt[i] <= lane_cnt[i] + 1'b1;
                end
              end
            end else if (i_valid_mismatch && (vld_cnt != CNT_MAX)) begin
              vld_cnt <= vld_cnt + 1'b1;
            end
            // The final beat is counted on the same edge that leaves RUN.
            if (beat_nxt == len_q) begin
              state            <= EVAL;
              o_pattern_gen_en <= 1'b0;
            end
          end
        end

        EVAL: begin
          if (!i_point_test_en) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else begin
            state            <= DONE;
            o_lanes_result   <= pass_vec;
            o_point_test_ack <= 1'b1;
          end
        end

        DONE: begin
          // Ack tracks en; results stay put through the return to IDLE.
          o_point_test_ack <= i_point_test_en;
          if (!i_point_test_en) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end

        default: begin
          state            <= IDLE;
          o_busy           <= 1'b0;
          o_pattern_gen_en <= 1'b0;
          o_point_test_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_point_test_checker.sv
// Bench for point_test_checker: directed point tests checked against a
// behavioural model every cycle, plus literal expectations on results and
// ack latency.
module tb_point_test_checker;

  localparam int LANES   = 16;
  localparam int CNT_W   = 4;
  localparam int LEN_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_point_test_en;
  logic             i_tx_lfsr_or_perlane;
  logic             i_tx_mainband_or_valtrain_test;
  logic [LEN_W-1:0] i_test_length;
  logic [CNT_W-1:0] i_error_threshold;
  logic             i_beat_valid;
  logic [LANES-1:0] i_lane_mismatch;
  logic             i_valid_mismatch;
  logic             o_pattern_gen_en;
  logic             o_pattern_lfsr;
  logic             o_point_test_ack;
  logic [LANES-1:0] o_lanes_result;
  logic             o_busy;

  always #5 clk = ~clk;

  point_test_checker #(.LANES(LANES), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk                            (clk),
    .rst                            (rst),
    .i_point_test_en                (i_point_test_en),
    .i_tx_lfsr_or_perlane           (i_tx_lfsr_or_perlane),
    .i_tx_mainband_or_valtrain_test (i_tx_mainband_or_valtrain_test),
    .i_test_length                  (i_test_length),
    .i_error_threshold              (i_error_threshold),
    .i_beat_valid                   (i_beat_valid),
    .i_lane_mismatch                (i_lane_mismatch),
    .i_valid_mismatch               (i_valid_mismatch),
    .o_pattern_gen_en               (o_pattern_gen_en),
    .o_pattern_lfsr                 (o_pattern_lfsr),
    .o_point_test_ack               (o_point_test_ack),
    .o_lanes_result                 (o_lanes_result),
    .o_busy                         (o_busy)
  );

  int total = 0;
  int bad   = 0;

  // Model: a test is "active" from the en-sampling edge until evaluation or
  // abort; "done" while results are being acknowledged. Error counts are kept
  // unbounded and only clipped to the counter range when judged.
  bit          m_active, m_done, m_cfg, m_mb, m_lfsr;
  int          m_age, m_beats, m_len, m_thr;
  int          m_err [LANES+1];
  logic [15:0] m_result;

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_active = 0; m_done = 0; m_cfg = 0; m_lfsr = 0;
      m_result = '0; m_len = 0; m_beats = 0;
      return;
    end
    if (m_done) begin
      if (!i_point_test_en) m_done = 0;
    end else if (m_active) begin
      m_age++;
      if (!i_point_test_en) begin
        m_active = 0;
      end else if (m_age == 1) begin
        m_cfg  = 1;
        m_len  = int'(i_test_length);
        m_thr  = int'(i_error_threshold);
        m_mb   = i_tx_mainband_or_valtrain_test;
        m_lfsr = i_tx_lfsr_or_perlane;
      end else if (m_beats < m_len) begin
        if (i_beat_valid) begin
          m_beats++;
          if (m_mb) begin
            for (int i = 0; i < LANES; i++)
              if (i_lane_mismatch[i]) m_err[i]++;
          end else if (i_valid_mismatch) begin
            m_err[LANES]++;
          end
        end
      end else begin
        for (int i = 0; i < LANES; i++)
          m_result[i] = m_mb ? (sat(m_err[i]) <= m_thr) : (sat(m_err[LANES]) <= m_thr);
        m_active = 0;
        m_done   = 1;
      end
    end else if (i_point_test_en) begin
      m_active = 1; m_age = 0; m_cfg = 0; m_beats = 0; m_result = '0;
      for (int i = 0; i <= LANES; i++) m_err[i] = 0;
    end
  endtask

  // One clock: advance the model on the edge, compare on the falling edge.
  task automatic tick();
    logic e_busy, e_gen, e_ack;
    @(posedge clk);
    model_step();
    @(negedge clk);
    e_busy = m_active || m_done;
    e_gen  = m_active && m_cfg && (m_beats < m_len);
    e_ack  = m_done;
    total++;
    if (o_busy !== e_busy || o_pattern_gen_en !== e_gen || o_point_test_ack !== e_ack ||
        o_pattern_lfsr !== m_lfsr || o_lanes_result !== m_result) begin
      bad++;
      $display("FAIL cycle_compare t=%0t busy/gen/lfsr/ack/res got %b/%b/%b/%b/%h required %b/%b/%b/%b/%h",
               $time, o_busy, o_pattern_gen_en, o_pattern_lfsr, o_point_test_ack, o_lanes_result,
               e_busy, e_gen, m_lfsr, e_ack, m_result);
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got %0h required %0h", name, got, exp);
    end
  endtask

  // Per-test stimulus, k = number of the clock about to be issued since en
  // was raised (the first counted RUN beat is k = 3). Returns {valid, vmis, lanes}.
  function automatic logic [17:0] pat(input int id, input int k);
    logic        v;
    logic        vm;
    logic [15:0] l;
    v = 1'b1; vm = 1'b0; l = '0;
    case (id)
      2: begin
        if (k >= 3 && k <= 5) l[5] = 1'b1;
        if (k == 6 || k == 7) l[0] = 1'b1;
      end
      3: begin l = '1; vm = (k == 4); end
      4: l[3] = 1'b1;
      6: begin
        v = k[0];
        if (!v) begin l[7] = 1'b1; vm = 1'b1; end
        else if (k == 5) l[1] = 1'b1;
      end
      7: l = '1;
      9: begin l = '1; vm = 1'b1; end
      default: ;
    endcase
    return {v, vm, l};
  endfunction

  task automatic run_test(input int id, input logic mb, input logic lf, input int len,
                          input int thr, input int abort_k, output int lat);
    logic [17:0] p;
    lat = -1;
    i_tx_mainband_or_valtrain_test = mb;
    i_tx_lfsr_or_perlane = lf;
    i_test_length = LEN_W'(len);
    i_error_threshold = CNT_W'(thr);
    i_point_test_en = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      p = pat(id, k);
      i_beat_valid = p[17];
      i_valid_mismatch = p[16];
      i_lane_mismatch = p[15:0];
      if (k == abort_k) i_point_test_en = 1'b0;
      tick();
      if (o_point_test_ack === 1'b1 && lat < 0) lat = k;
      if (abort_k > 0 && k >= abort_k + 2) break;
      if (abort_k == 0 && lat >= 0) break;
    end
    if (abort_k == 0 && lat < 0) begin
      total++; bad++;
      $display("FAIL ack_timeout test %0d got no ack required ack within 200 cycles", id);
    end
    i_point_test_en = 1'b0; i_beat_valid = 1'b0;
    i_lane_mismatch = '0; i_valid_mismatch = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int lat;
    rst = 1'b1; i_point_test_en = 1'b0; i_tx_lfsr_or_perlane = 1'b0;
    i_tx_mainband_or_valtrain_test = 1'b1; i_test_length = '0; i_error_threshold = '0;
    i_beat_valid = 1'b0; i_lane_mismatch = '0; i_valid_mismatch = 1'b0;
    m_result = '0;
    repeat (3) tick();
    check("reset_result", int'(o_lanes_result), 0);
    check("reset_busy", int'(o_busy), 0);
    check("reset_ack", int'(o_point_test_ack), 0);
    rst = 1'b0;
    tick();

    run_test(1, 1'b1, 1'b1, 8, 0, 0, lat);
    check("clean_len8_latency", lat, 11);
    check("clean_len8_result", int'(o_lanes_result), 'hFFFF);
    check("clean_len8_lfsr", int'(o_pattern_lfsr), 1);

    run_test(2, 1'b1, 1'b0, 8, 2, 0, lat);
    check("thr2_result", int'(o_lanes_result), 'hFFDF);
    check("thr2_lfsr", int'(o_pattern_lfsr), 0);
    repeat (3) tick();
    check("idle_retains_result", int'(o_lanes_result), 'hFFDF);

    run_test(3, 1'b0, 1'b0, 4, 0, 0, lat);
    check("valtrain_result", int'(o_lanes_result), 'h0000);

    run_test(4, 1'b1, 1'b0, 40, 15, 0, lat);
    check("saturate_thr15_latency", lat, 43);
    check("saturate_thr15_result", int'(o_lanes_result), 'hFFFF);
    run_test(4, 1'b1, 1'b0, 40, 14, 0, lat);
    check("saturate_thr14_result", int'(o_lanes_result), 'hFFF7);

    run_test(6, 1'b1, 1'b1, 4, 0, 0, lat);
    check("gapped_valid_result", int'(o_lanes_result), 'hFFFD);

    run_test(7, 1'b1, 1'b0, 8, 0, 5, lat);
    check("abort_no_ack", lat, -1);
    check("abort_result", int'(o_lanes_result), 0);
    run_test(1, 1'b1, 1'b0, 8, 0, 0, lat);
    check("reenable_latency", lat, 11);
    check("reenable_result", int'(o_lanes_result), 'hFFFF);

    run_test(9, 1'b0, 1'b1, 0, 0, 0, lat);
    check("len0_latency", lat, 3);
    check("len0_result", int'(o_lanes_result), 'hFFFF);

    rst = 1'b1;
    tick();
    check("rst_idle_clears_result", int'(o_lanes_result), 0);
    rst = 1'b0;
    tick();

    i_tx_mainband_or_valtrain_test = 1'b1; i_tx_lfsr_or_perlane = 1'b1;
    i_test_length = LEN_W'(8); i_error_threshold = '0; i_beat_valid = 1'b1;
    i_point_test_en = 1'b1;
    repeat (5) tick();
    check("run_gen_en_before_rst", int'(o_pattern_gen_en), 1);
    rst = 1'b1;
    tick();
    check("rst_run_gen_en", int'(o_pattern_gen_en), 0);
    check("rst_run_busy", int'(o_busy), 0);
    check("rst_run_lfsr", int'(o_pattern_lfsr), 0);
    check("rst_run_ack", int'(o_point_test_ack), 0);
    check("rst_run_result", int'(o_lanes_result), 0);
    rst = 1'b0; i_point_test_en = 1'b0; i_beat_valid = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
